// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_ctrl_pkg
// Description : Shared types and constants for the ring-oscillator PUF
//               challenge sequencer: FSM state encoding, ring-phase flag,
//               default phase lengths and small elaboration-time helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_ctrl_pkg;

  // Sequencer states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_RUN     = 3'd3,
    S_HOLD    = 3'd4,
    S_CAPTURE = 3'd5,
    S_COMPARE = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Which ring of the current response bit is being measured
  typedef enum logic {
    RING_A = 1'b0,
    RING_B = 1'b1
  } ring_t;

  // Default phase lengths in clock cycles
  localparam int c_def_settle_cycles = 4;
  localparam int c_def_window_cycles = 1000;
  localparam int c_def_hold_cycles   = 4;

  // Largest of three values, used to size the shared phase timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // $clog2 that never returns a zero width
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : puf_phase_timer
// Description : Loadable down-counter shared by the SETTLE, RUN and HOLD
//               phases. Loading N-1 yields a phase of exactly N cycles; tc is
//               high while the count sits at zero. The counter stops at zero
//               rather than wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] r_cnt;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenge_sequencer
// Description : Drives the ring-oscillator PUF chain. For each response bit
//               it measures ring A then ring B over a fixed window
//               (CLEAR / SETTLE / RUN / HOLD / CAPTURE), compares the two
//               counts and assembles the response. Optional build macro
//               PUF_TIE_MASK_EN adds a tie_mask output flagging equal counts.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int SEL_W         = 2,
  parameter int COUNT_W       = 32,
  parameter int RESP_BITS     = 4,
  parameter int SETTLE_CYCLES = c_def_settle_cycles,
  parameter int WINDOW_CYCLES = c_def_window_cycles,
  parameter int HOLD_CYCLES   = c_def_hold_cycles
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2*SEL_W*RESP_BITS-1:0] challenge,
  output logic                         busy,
  output logic                         done,
  output logic [RESP_BITS-1:0]         response,
  output logic [SEL_W-1:0]             mux_sel,
  output logic                         puf_enable,
  output logic                         reset_counter,
`ifdef PUF_TIE_MASK_EN
  output logic [RESP_BITS-1:0]         tie_mask,
`endif
  input  logic [COUNT_W-1:0]           count_in
);

  localparam int c_chal_w = 2 * SEL_W * RESP_BITS;
  localparam int c_idx_w  = clog2_min1(RESP_BITS);
  localparam int c_tmr_w  = clog2_min1(max3(SETTLE_CYCLES, WINDOW_CYCLES, HOLD_CYCLES));

  state_t               r_state;
  state_t               w_next_state;
  ring_t                r_ring;
  logic [c_chal_w-1:0]  r_chal;
  logic [COUNT_W-1:0]   r_count_a;
  logic [COUNT_W-1:0]   r_count_b;
  logic [c_idx_w-1:0]   r_idx;
  logic [RESP_BITS-1:0] r_response;
  logic [SEL_W-1:0]     r_mux_sel;

  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_tmr_load_val;
  logic                 w_tmr_tc;
  logic                 w_last;
  logic [c_idx_w-1:0]   w_next_idx;
  logic [c_chal_w-1:0]  w_chal_b_shift;
  logic [c_chal_w-1:0]  w_chal_next_a_shift;
  logic [SEL_W-1:0]     w_sel_b;
  logic [SEL_W-1:0]     w_sel_next_a;

  // Ring selects: B of the current bit, and A of the following bit
  assign w_last              = (r_idx == c_idx_w'(RESP_BITS - 1));
  assign w_next_idx          = r_idx + 1'b1;
  assign w_chal_b_shift      = r_chal >> (int'(r_idx) * 2 * SEL_W + SEL_W);
  assign w_chal_next_a_shift = r_chal >> (int'(w_next_idx) * 2 * SEL_W);
  assign w_sel_b             = w_chal_b_shift[SEL_W-1:0];
  assign w_sel_next_a        = w_chal_next_a_shift[SEL_W-1:0];

  // State register; async reset drops puf_enable at once via the output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_CLEAR;
      S_CLEAR:   w_next_state = S_SETTLE;
      S_SETTLE:  if (w_tmr_tc) w_next_state = S_RUN;
      S_RUN:     if (w_tmr_tc) w_next_state = S_HOLD;
      S_HOLD:    if (w_tmr_tc) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = (r_ring == RING_A) ? S_CLEAR : S_COMPARE;
      S_COMPARE: w_next_state = w_last ? S_DONE : S_CLEAR;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode: chain controls and system handshake come straight from state
  always_comb begin
    busy          = 1'b1;
    done          = 1'b0;
    puf_enable    = 1'b0;
    reset_counter = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      S_CLEAR: reset_counter = 1'b1;
      S_RUN:   puf_enable = 1'b1;
      default: ;
    endcase
  end

  // Timer is reloaded on every entry into a timed phase with that phase's length
  always_comb begin
    w_tmr_load     = (w_next_state != r_state);
    w_tmr_load_val = '0;
    case (w_next_state)
      S_SETTLE: w_tmr_load_val = c_tmr_w'(SETTLE_CYCLES - 1);
      S_RUN:    w_tmr_load_val = c_tmr_w'(WINDOW_CYCLES - 1);
      S_HOLD:   w_tmr_load_val = c_tmr_w'(HOLD_CYCLES - 1);
      default:  w_tmr_load     = 1'b0;
    endcase
  end

  puf_phase_timer #(
    .WIDTH (c_tmr_w)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_load_val),
    .tc       (w_tmr_tc)
  );

  // Datapath: latch challenge, steer the mux on CLEAR entry, capture and compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring     <= RING_A;
      r_chal     <= '0;
      r_count_a  <= '0;
      r_count_b  <= '0;
      r_idx      <= '0;
      r_response <= '0;
      r_mux_sel  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal     <= challenge;
            r_idx      <= '0;
            r_ring     <= RING_A;
            r_response <= '0;
            r_mux_sel  <= challenge[SEL_W-1:0];
          end
        end
        S_CAPTURE: begin
          if (r_ring == RING_A) begin
            r_count_a <= count_in;
            r_ring    <= RING_B;
            r_mux_sel <= w_sel_b;
          end else begin
            r_count_b <= count_in;
          end
        end
        S_COMPARE: begin
          r_response[r_idx] <= (r_count_a > r_count_b);
          r_ring            <= RING_A;
          if (!w_last) begin
            r_idx     <= w_next_idx;
            r_mux_sel <= w_sel_next_a;
          end
        end
        default: ;
      endcase
    end
  end

  assign response = r_response;
  assign mux_sel  = r_mux_sel;

`ifdef PUF_TIE_MASK_EN
  logic [RESP_BITS-1:0] r_tie_mask;

  // Flag bits whose two counts were equal so firmware can discard them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tie_mask <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_tie_mask <= '0;
    end else if (r_state == S_COMPARE) begin
      r_tie_mask[r_idx] <= (r_count_a == r_count_b);
    end
  end

  assign tie_mask = r_tie_mask;
`else
  // Tie tracking is not built; the response path is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_challenge_sequencer
// Description : Self-checking bench for puf_challenge_sequencer. A simple
//               chain model returns a fixed count per ring once the window
//               has closed (garbage during HOLD); expected responses come from
//               comparing those per-ring counts directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_challenge_sequencer;

  localparam int SEL_W     = 2;
  localparam int COUNT_W   = 32;
  localparam int RESP_BITS = 2;
  localparam int SETTLE    = 2;
  localparam int WINDOW    = 16;
  localparam int HOLD      = 2;
  localparam int CHAL_W    = 2 * SEL_W * RESP_BITS;
  localparam int R         = SETTLE + WINDOW + HOLD + 2;
  localparam int LATENCY   = RESP_BITS * (2 * R + 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CHAL_W-1:0]    challenge = '0;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic [SEL_W-1:0]     mux_sel;
  logic                 puf_enable;
  logic                 reset_counter;
  logic [COUNT_W-1:0]   count_in = '0;
`ifdef PUF_TIE_MASK_EN
  logic [RESP_BITS-1:0] tie_mask;
`endif

  logic [COUNT_W-1:0] ring_val [4];
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 mux_seq [$];

  // chain-model / monitor state
  int               rc_len = 0;
  int               gap = 0;
  int               pe_len = 0;
  int               since_fall = 0;
  int               run_cnt = 0;
  bit               window_seen = 1'b0;
  logic [SEL_W-1:0] prev_mux = '0;

  puf_challenge_sequencer #(
    .SEL_W         (SEL_W),
    .COUNT_W       (COUNT_W),
    .RESP_BITS     (RESP_BITS),
    .SETTLE_CYCLES (SETTLE),
    .WINDOW_CYCLES (WINDOW),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .challenge     (challenge),
    .busy          (busy),
    .done          (done),
    .response      (response),
    .mux_sel       (mux_sel),
    .puf_enable    (puf_enable),
    .reset_counter (reset_counter),
`ifdef PUF_TIE_MASK_EN
    .tie_mask      (tie_mask),
`endif
    .count_in      (count_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Chain model and chain-side protocol monitor, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      rc_len = 0; gap = 0; pe_len = 0; since_fall = 0; run_cnt = 0;
      window_seen = 1'b0;
      count_in = '0;
    end else begin
      if (reset_counter) begin
        if (rc_len == 0) mux_seq.push_back(int'(mux_sel));
        check("pe_with_rc", puf_enable, 0);
        rc_len++; gap = 0; window_seen = 1'b0; run_cnt = 0; since_fall = 0;
        count_in = '0;
      end else begin
        if (rc_len != 0) begin
          check("rc_pulse_len", rc_len, 1);
          rc_len = 0;
        end
        if (puf_enable) begin
          if (pe_len == 0) check("settle_len", gap, SETTLE);
          check("mux_stable_in_window", mux_sel, prev_mux);
          pe_len++; window_seen = 1'b1; since_fall = 0; run_cnt++;
          count_in = COUNT_W'(run_cnt);
        end else begin
          if (pe_len != 0) begin
            check("window_len", pe_len, WINDOW);
            pe_len = 0;
          end
          gap++;
          if (window_seen) begin
            since_fall++;
            // the counter is still settling during HOLD: present a wrong value
            if (since_fall <= HOLD)
              count_in = ring_val[mux_sel] ^ (COUNT_W'($urandom) | COUNT_W'(1));
            else
              count_in = ring_val[mux_sel];
          end
        end
      end
      prev_mux = mux_sel;
    end
  end

  // One full challenge; optionally pulses start with a different challenge mid-RUN
  task automatic run_chal(input logic [CHAL_W-1:0] chal, input bit inject, input string tag);
    logic [RESP_BITS-1:0] exp_resp;
    logic [RESP_BITS-1:0] exp_tie;
    int                   exp_seq [$];
    int                   n;
    int                   a;
    int                   b;
    for (int i = 0; i < RESP_BITS; i++) begin
      a = int'(chal[2*SEL_W*i +: SEL_W]);
      b = int'(chal[2*SEL_W*i + SEL_W +: SEL_W]);
      exp_resp[i] = (ring_val[a] > ring_val[b]);
      exp_tie[i]  = (ring_val[a] == ring_val[b]);
      exp_seq.push_back(a);
      exp_seq.push_back(b);
    end
    @(negedge clk);
    mux_seq.delete();
    start = 1'b1;
    challenge = chal;
    @(posedge clk);
    #1;
    start = 1'b0;
    challenge = CHAL_W'($urandom);
    check({tag, "_busy_after_accept"}, busy, 1);
    n = 0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (inject && n == 30) begin
        start = 1'b1;
        challenge = ~chal;
      end else if (inject && n == 31) begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, n, LATENCY);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_response"}, response, exp_resp);
`ifdef PUF_TIE_MASK_EN
    check({tag, "_tie_mask"}, tie_mask, exp_tie);
`endif
    check({tag, "_mux_seq_len"}, mux_seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < mux_seq.size(); i++)
      check({tag, "_mux_seq"}, mux_seq[i], exp_seq[i]);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    repeat (5) @(negedge clk);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_response_held"}, response, exp_resp);
  endtask

  initial begin
    bit seen_done;
    for (int k = 0; k < 4; k++) ring_val[k] = '0;

    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_puf_enable", puf_enable, 0);
    check("rst_reset_counter", reset_counter, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_response", response, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ring0=500, ring1=300; A0=0 B0=1 A1=1 B1=0 -> 2'b01
    ring_val[0] = 500; ring_val[1] = 300;
    run_chal(8'h14, 1'b0, "basic");

    // ties give 0
    ring_val[0] = 400; ring_val[1] = 400;
    run_chal(8'h14, 1'b0, "tie");

    // start pulse mid-RUN is ignored
    ring_val[0] = 500; ring_val[1] = 300; ring_val[2] = 700; ring_val[3] = 100;
    run_chal(8'h14, 1'b1, "mid_start");

    // unsigned compare, captured value is the CAPTURE-cycle one
    ring_val[2] = 32'hFFFF_FFFF; ring_val[3] = 32'h0;
    run_chal(8'hBE, 1'b0, "unsigned");

    // reset during RUN of bit 1
    ring_val[0] = 500; ring_val[1] = 300;
    @(negedge clk);
    start = 1'b1;
    challenge = 8'h14;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (55) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_in_run", puf_enable, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_puf_enable", puf_enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_reset_counter", reset_counter, 0);
    check("midrst_mux_sel", mux_sel, 0);
    check("midrst_response", response, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 0);
    run_chal(8'h14, 1'b0, "after_rst");

    // randomized challenges and ring counts (small range to hit ties)
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++) ring_val[k] = COUNT_W'($urandom_range(0, 5) * 100);
      run_chal(CHAL_W'($urandom), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Controller for the ring-oscillator PUF chain (ring mux, PUF enable, counter clear, 32-bit count).
- For each response bit, measures two rings named by the challenge, one after the other, over a fixed clock window.
- Compares the two counts and builds an RESP_BITS-wide response.
- Owns mux_sel, puf_enable and reset_counter of the chain exclusively; a start/busy/done handshake faces the system side.

Parameters:
- SEL_W, 2, width of ring-mux select.
- COUNT_W, 32, width of chain counter.
- RESP_BITS, 4, response bits produced per challenge.
- SETTLE_CYCLES, 4, cycles with PUF disabled after the mux changes, before the window opens (≥1).
- WINDOW_CYCLES, 1000, cycles puf_enable is held high per ring (≥1).
- HOLD_CYCLES, 4, cycles after the window closes before count_in is sampled, so the async counter can stop (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a measurement; accepted only in IDLE
- challenge  in  2*SEL_W*RESP_BITS  per bit i: ring A = challenge[2*SEL_W*i +: SEL_W], ring B = next SEL_W bits
- busy  out  1  high while a challenge is in progress
- done  out  1  one-cycle pulse when response is valid
- response  out  RESP_BITS  bit i = 1 iff count(A_i) > count(B_i)
- mux_sel  out  SEL_W  drives the chain's ring mux
- puf_enable  out  1  enables the oscillator chain
- reset_counter  out  1  active-high clear to the chain counter
- count_in  in  COUNT_W  chain counter value

Behaviour:
- Reset, async while rst_n=0:
  - State IDLE.
  - busy, done, puf_enable and reset_counter are 0.
  - mux_sel and response are 0.
  - Internal challenge copy, count_a and bit index are 0.
- Reset mid-operation: puf_enable drops to 0 immediately (asynchronously); no done pulse.
- IDLE:
  - start=1 latches challenge, clears response and sets bit index to 0, then goes to CLEAR.
  - Later challenge changes are ignored.
  - start while busy is ignored.
- Per ring measurement (ring A, then ring B):
  - CLEAR, 1 cycle: mux_sel is set to the ring; reset_counter=1; puf_enable=0.
  - SETTLE, SETTLE_CYCLES: reset_counter=0, puf_enable=0.
  - RUN, WINDOW_CYCLES: puf_enable=1.
  - HOLD, HOLD_CYCLES: puf_enable=0.
  - CAPTURE, 1 cycle: count_in is sampled into count_a (ring A) or count_b (ring B).
- COMPARE, 1 cycle:
  - response[index] = (count_a > count_b), unsigned.
  - Tie gives 0.
  - Index increments; go to CLEAR for the next bit, or DONE after the last bit.
- DONE, 1 cycle: done=1, busy=0, then IDLE. response holds until the next accepted start or reset.
- busy is 1 in every state except IDLE and DONE.
- Latency:
  - Per ring: R = SETTLE_CYCLES + WINDOW_CYCLES + HOLD_CYCLES + 2.
  - From the start-accept edge to the done-high edge: RESP_BITS*(2R+1)+1 cycles.
- Same-ring challenge (A==B): measured normally; tie, so the bit is 0.
- puf_enable is never 1 in the same cycle as reset_counter or in a cycle where mux_sel changes.
- Window counter: $clog2 of the largest of SETTLE/WINDOW/HOLD; reloaded on each phase entry; no wrap.

Optional Feature:
- Macro PUF_TIE_MASK_EN.
- Defined:
  - Extra output tie_mask[RESP_BITS]; bit i = 1 iff count_a == count_b at bit i.
  - Updated in COMPARE; cleared on start-accept and reset.
  - Lets firmware discard unstable bits.
- Undefined: no port, no logic. response is identical in both builds.

Decomposition:
- Package puf_ctrl_pkg holds:
  - state enum: IDLE, CLEAR, SETTLE, RUN, HOLD, CAPTURE, COMPARE, DONE;
  - ring-phase flag (A/B);
  - default constants for SETTLE/WINDOW/HOLD.
- Sub-module puf_phase_timer:
  - loadable down-counter with load value and terminal-count pulse;
  - reused for SETTLE, RUN and HOLD.

Test Plan (SETTLE=2, WINDOW=16, HOLD=2, RESP_BITS=2, R=22):
- Model counter returns 500 for ring 0, 300 for ring 1; challenge A0=0, B0=1, A1=1, B1=0 -> response=2'b01, done exactly 91 cycles after start-accept, busy low in the DONE cycle.
- Same setup, monitor chain outputs -> each ring shows 1 cycle reset_counter, 2 idle, exactly 16 consecutive puf_enable cycles, 2 hold; mux_sel sequence 0,1,1,0.
- Equal counts (400/400) -> response bit 0; with PUF_TIE_MASK_EN, tie_mask bit set.
- start pulsed again mid-RUN with a new challenge -> ignored, original challenge completes, single done.
- rst_n low during RUN of bit 1 -> puf_enable 0 same cycle, outputs at reset values, no done; new start after release gives correct full-length run.
- count_in changes during HOLD, stable at CAPTURE -> captured value is the CAPTURE-cycle value (e.g. 32'hFFFF_FFFF vs 32'h0 -> bit 1, unsigned compare).
